// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM port between an instruction-fetch requester
// and a data (load/store) requester.
//
// Ports
//   cpu_clk_50M              system clock, all state changes on rising edge
//   cpu_rst                  synchronous active-high reset
//   ice / iaddr              fetch request (held until inst_valid) and address
//   inst / inst_valid        registered fetched word and its one-cycle pulse
//   dce / dwe / daddr /
//   dwdata                   data request (held until d_valid), byte enables
//                            (0 = read), address and store data
//   drdata / d_valid         registered load result and its one-cycle pulse
//   flush                    pipeline flush: blocks grants, aborts fetches
//   stallreq                 combinational stall request to the pipeline
//   sram_ce/we/addr/wdata    shared SRAM request, zero outside an access
//   sram_rdata               SRAM read data, sampled on the last access cycle
//
// Each granted access occupies the SRAM for exactly MEM_LAT cycles (1..7);
// the valid pulse follows in the next cycle, back in IDLE.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        ice,
  input  logic [31:0] iaddr,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        dce,
  input  logic [3:0]  dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        d_valid,
  input  logic        flush,
  output logic        stallreq,
  output logic        sram_ce,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  we_reg;
  logic        grant_d, grant_i, last_acc;
  logic        acc_i, acc_d;

  // A requester whose valid is high this cycle is still holding its request
  // for one more cycle; it is masked so the same request is not served twice.
  always_comb begin
    grant_d  = (state_reg == IDLE) && dce && !d_valid && !flush;
    grant_i  = (state_reg == IDLE) && ice && !inst_valid && !flush && !grant_d;
    last_acc = (cnt_reg == LAST_CNT);
  end

  // State register
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; the counter restarts at 0 on every state entry and
  // stops at MEM_LAT-1, so it can never wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 3'd0;
        if (grant_d)      state_next = ACC_D;
        else if (grant_i) state_next = ACC_I;
      end
      ACC_I: begin
        // A flush kills a fetch even on its final cycle.
        if (flush || last_acc) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      ACC_D: begin
        // Stores/loads already on the bus are never aborted by flush.
        if (last_acc) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Request latch and result registers
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      we_reg     <= 4'd0;
      inst       <= 32'd0;
      drdata     <= 32'd0;
      inst_valid <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      d_valid    <= 1'b0;
      if (grant_d) begin
        addr_reg  <= daddr;
        we_reg    <= dwe;
        wdata_reg <= dwdata;
      end else if (grant_i) begin
        addr_reg  <= iaddr;
        we_reg    <= 4'd0;
        wdata_reg <= 32'd0;
      end
      if (state_reg == ACC_I && last_acc && !flush) begin
        inst       <= sram_rdata;
        inst_valid <= 1'b1;
      end
      if (state_reg == ACC_D && last_acc) begin
        drdata  <= sram_rdata;
        d_valid <= 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    acc_i     = (state_reg == ACC_I);
    acc_d     = (state_reg == ACC_D);
    sram_ce   = acc_i || acc_d;
    sram_addr = sram_ce ? addr_reg : 32'd0;
    sram_we   = acc_d ? we_reg : 4'd0;
    // While in reset the state register may not yet be IDLE; report the
    // stall as IDLE with both valids low would.
    if (cpu_rst)
      stallreq = ice || dce;
    else
      stallreq = (state_reg != IDLE) || (ice && !inst_valid) || (dce && !d_valid);
  end

  // Store data lanes are only driven during a data access.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sram_wdata[8*gi +: 8] = acc_d ? wdata_reg[8*gi +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        ice, dce, flush;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dwe;
  logic [31:0] inst, drdata, sram_addr, sram_wdata, sram_rdata;
  logic        inst_valid, d_valid, stallreq, sram_ce;
  logic [3:0]  sram_we;

  // auxiliary instances for the latency sweep
  logic        ice1, ice7;
  logic [31:0] iaddr1, iaddr7;
  logic [31:0] inst1, inst7, dr1, dr7, addr1, addr7, wd1, wd7, rd1, rd7;
  logic        iv1, iv7, dv1, dv7, st1, st7, ce1, ce7;
  logic [3:0]  we1, we7;

  logic [31:0] tb_cyc = 32'd0;
  logic        rdata_fix_en = 1'b0;
  logic [31:0] rdata_fix = 32'd0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 32'd1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // SRAM model: data depends on address and on the cycle it is sampled in,
  // so sampling on the wrong access cycle gives a different word.
  assign sram_rdata = rdata_fix_en ? rdata_fix : (hash(sram_addr) ^ tb_cyc);
  assign rd1 = hash(addr1) ^ tb_cyc;
  assign rd7 = hash(addr7) ^ tb_cyc;

  mem_arbiter #(.MEM_LAT(2)) dut (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .ice(ice), .iaddr(iaddr), .inst(inst),
    .inst_valid(inst_valid), .dce(dce), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .d_valid(d_valid), .flush(flush), .stallreq(stallreq),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

  mem_arbiter #(.MEM_LAT(1)) dut_l1 (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .ice(ice1), .iaddr(iaddr1), .inst(inst1),
    .inst_valid(iv1), .dce(1'b0), .dwe(4'd0), .daddr(32'd0), .dwdata(32'd0),
    .drdata(dr1), .d_valid(dv1), .flush(1'b0), .stallreq(st1),
    .sram_ce(ce1), .sram_we(we1), .sram_addr(addr1),
    .sram_wdata(wd1), .sram_rdata(rd1));

  mem_arbiter #(.MEM_LAT(7)) dut_l7 (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .ice(ice7), .iaddr(iaddr7), .inst(inst7),
    .inst_valid(iv7), .dce(1'b0), .dwe(4'd0), .daddr(32'd0), .dwdata(32'd0),
    .drdata(dr7), .d_valid(dv7), .flush(1'b0), .stallreq(st7),
    .sram_ce(ce7), .sram_we(we7), .sram_addr(addr7),
    .sram_wdata(wd7), .sram_rdata(rd7));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; ice = 1'b1;
    next_cycle(); next_cycle();
    @(negedge clk);
    total++;
    if (stallreq !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b exp=1", stallreq); end
    total++;
    if ({sram_ce, sram_we, sram_addr, sram_wdata, inst_valid, d_valid, inst, drdata} !== '0) begin
      bad++; $display("FAIL rst_outputs got=%h exp=0",
        {sram_ce, sram_we, sram_addr, sram_wdata, inst_valid, d_valid, inst, drdata});
    end
    ice = 1'b0; #1;
    total++;
    if (stallreq !== 1'b0) begin bad++; $display("FAIL rst_stall_idle got=%b exp=0", stallreq); end
    next_cycle();
    cpu_rst = 1'b0;
    next_cycle();
    $display("reset: done");
  endtask

  task automatic test_fetch();
    rdata_fix_en = 1'b1; rdata_fix = 32'h24080001;
    ice = 1'b1; iaddr = 32'hBFC00000;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (sram_ce !== (c == 1 || c == 2)) begin bad++; $display("FAIL fetch_ce c=%0d got=%b", c, sram_ce); end
      total++;
      if (sram_addr !== ((c == 1 || c == 2) ? 32'hBFC00000 : 32'd0)) begin
        bad++; $display("FAIL fetch_addr c=%0d got=%h", c, sram_addr);
      end
      total++;
      if (inst_valid !== (c == 3)) begin bad++; $display("FAIL fetch_iv c=%0d got=%b", c, inst_valid); end
      total++;
      if (stallreq !== (c < 3)) begin bad++; $display("FAIL fetch_stall c=%0d got=%b", c, stallreq); end
      if (c == 3) begin
        total++;
        if (inst !== 32'h24080001) begin bad++; $display("FAIL fetch_inst got=%h exp=24080001", inst); end
      end
      next_cycle();
      if (c == 3) ice = 1'b0;
    end
    rdata_fix_en = 1'b0;
    $display("fetch: addr=bfc00000 inst=%h", inst);
  endtask

  // Drives one request set from IDLE and checks every cycle against the
  // timeline implied by the arbitration rules: data first for MEM_LAT cycles,
  // its valid the cycle after, then the fetch starting in that valid cycle.
  task automatic run_txn(input bit do_i, input bit do_d, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] dw, input logic [3:0] we);
    int L, si, fin;
    logic [31:0] t0, e_addr, e_wd;
    logic [3:0]  e_we;
    bit ce_d, ce_i, e_dv, e_iv;
    L = 2;
    ice = do_i; iaddr = ia; dce = do_d; daddr = da; dwdata = dw; dwe = we;
    t0 = tb_cyc;
    si = do_d ? L + 1 : 0;
    fin = do_i ? si + L + 1 : L + 1;
    for (int c = 0; c <= fin + 1; c++) begin
      ce_d = do_d && c >= 1 && c <= L;
      ce_i = do_i && c >= si + 1 && c <= si + L;
      e_addr = ce_d ? da : (ce_i ? ia : 32'd0);
      e_we = ce_d ? we : 4'd0;
      e_wd = ce_d ? dw : 32'd0;
      e_dv = do_d && c == L + 1;
      e_iv = do_i && c == si + L + 1;
      @(negedge clk);
      total++;
      if (sram_ce !== (ce_d || ce_i)) begin bad++; $display("FAIL txn_ce c=%0d got=%b", c, sram_ce); end
      total++;
      if (sram_addr !== e_addr) begin bad++; $display("FAIL txn_addr c=%0d got=%h exp=%h", c, sram_addr, e_addr); end
      total++;
      if (sram_we !== e_we) begin bad++; $display("FAIL txn_we c=%0d got=%h exp=%h", c, sram_we, e_we); end
      total++;
      if (sram_wdata !== e_wd) begin bad++; $display("FAIL txn_wdata c=%0d got=%h exp=%h", c, sram_wdata, e_wd); end
      total++;
      if (d_valid !== e_dv) begin bad++; $display("FAIL txn_dv c=%0d got=%b exp=%b", c, d_valid, e_dv); end
      total++;
      if (inst_valid !== e_iv) begin bad++; $display("FAIL txn_iv c=%0d got=%b exp=%b", c, inst_valid, e_iv); end
      total++;
      if (stallreq !== (c < fin)) begin bad++; $display("FAIL txn_stall c=%0d got=%b", c, stallreq); end
      if (e_dv) begin
        total++;
        if (drdata !== (hash(da) ^ (t0 + 32'(L)))) begin
          bad++; $display("FAIL txn_drdata got=%h exp=%h", drdata, hash(da) ^ (t0 + 32'(L)));
        end
      end
      if (e_iv) begin
        total++;
        if (inst !== (hash(ia) ^ (t0 + 32'(si + L)))) begin
          bad++; $display("FAIL txn_inst got=%h exp=%h", inst, hash(ia) ^ (t0 + 32'(si + L)));
        end
      end
      next_cycle();
      if (e_dv) dce = 1'b0;
      if (e_iv) ice = 1'b0;
    end
    $display("txn: i=%0b d=%0b ia=%h da=%h we=%h inst=%h drdata=%h", do_i, do_d, ia, da, we, inst, drdata);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b1, 32'hBFC00004, 32'h80000010, 32'hDEADBEEF, 4'hF);
  endtask

  task automatic test_flush_fetch();
    logic [31:0] inst_before;
    inst_before = inst;
    // flush while still IDLE blocks the grant
    ice = 1'b1; iaddr = 32'h00001234; flush = 1'b1;
    @(negedge clk);
    next_cycle();
    flush = 1'b0; ice = 1'b0;
    @(negedge clk);
    total++;
    if (sram_ce !== 1'b0) begin bad++; $display("FAIL flush_idle_ce got=%b exp=0", sram_ce); end
    next_cycle();
    // flush in the first ACC_I cycle aborts the fetch
    ice = 1'b1; iaddr = 32'h00005678;
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (sram_ce !== 1'b1) begin bad++; $display("FAIL flush_acc_ce got=%b exp=1", sram_ce); end
    next_cycle();
    flush = 1'b0; ice = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({sram_ce, stallreq, inst_valid} !== 3'b000) begin
        bad++; $display("FAIL flush_abort c=%0d got ce/stall/iv=%b exp=000", c, {sram_ce, stallreq, inst_valid});
      end
      total++;
      if (inst !== inst_before) begin bad++; $display("FAIL flush_inst got=%h exp=%h", inst, inst_before); end
      next_cycle();
    end
    $display("flush_fetch: inst=%h", inst);
  endtask

  task automatic test_flush_store();
    logic [31:0] t0;
    dce = 1'b1; dwe = 4'hF; daddr = 32'h80000020; dwdata = 32'hCAFEF00D;
    t0 = tb_cyc;
    for (int c = 0; c <= 3; c++) begin
      flush = (c == 1 || c == 2);
      @(negedge clk);
      if (c == 1 || c == 2) begin
        total++;
        if (sram_we !== 4'hF) begin bad++; $display("FAIL fstore_we c=%0d got=%h exp=f", c, sram_we); end
      end
      total++;
      if (d_valid !== (c == 3)) begin bad++; $display("FAIL fstore_dv c=%0d got=%b", c, d_valid); end
      if (c == 3) begin
        total++;
        if (drdata !== (hash(32'h80000020) ^ (t0 + 32'd2))) begin
          bad++; $display("FAIL fstore_drdata got=%h exp=%h", drdata, hash(32'h80000020) ^ (t0 + 32'd2));
        end
      end
      next_cycle();
    end
    flush = 1'b0; dce = 1'b0;
    next_cycle();
    $display("flush_store: drdata=%h", drdata);
  endtask

  task automatic test_reset_mid();
    dce = 1'b1; dwe = 4'hF; daddr = 32'h80000030; dwdata = 32'h11223344;
    next_cycle();
    next_cycle();
    cpu_rst = 1'b1;
    @(negedge clk);
    total++;
    if (stallreq !== 1'b1) begin bad++; $display("FAIL rmid_stall got=%b exp=1", stallreq); end
    next_cycle();
    cpu_rst = 1'b0; dce = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({sram_ce, sram_we, sram_addr, sram_wdata, inst_valid, d_valid, inst, drdata, stallreq} !== '0) begin
        bad++; $display("FAIL rmid_outputs c=%0d got=%h exp=0", c,
          {sram_ce, sram_we, sram_addr, sram_wdata, inst_valid, d_valid, inst, drdata, stallreq});
      end
      next_cycle();
    end
    run_txn(1'b1, 1'b0, 32'hBFC00100, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic test_lat_sweep();
    int lat1, lat7;
    logic [31:0] t0;
    lat1 = -1; lat7 = -1;
    ice1 = 1'b1; iaddr1 = 32'h00400010; ice7 = 1'b1; iaddr7 = 32'h00400070;
    t0 = tb_cyc;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (iv1 && lat1 < 0) begin
        lat1 = c;
        total++;
        if (inst1 !== (hash(32'h00400010) ^ (t0 + 32'(c - 1)))) begin bad++; $display("FAIL lat1_inst got=%h", inst1); end
      end
      if (iv7 && lat7 < 0) begin
        lat7 = c;
        total++;
        if (inst7 !== (hash(32'h00400070) ^ (t0 + 32'(c - 1)))) begin bad++; $display("FAIL lat7_inst got=%h", inst7); end
      end
      next_cycle();
      if (lat1 >= 0) ice1 = 1'b0;
      if (lat7 >= 0) ice7 = 1'b0;
    end
    total++;
    if (lat1 != 2) begin bad++; $display("FAIL lat1_latency got=%0d exp=2", lat1); end
    total++;
    if (lat7 != 8) begin bad++; $display("FAIL lat7_latency got=%0d exp=8", lat7); end
    total++;
    if ({dv1, dv7, st1, st7, ce1, ce7, we1, we7, wd1, wd7, dr1, dr7} !== '0) begin
      bad++; $display("FAIL lat_idle got=%h exp=0", {dv1, dv7, st1, st7, ce1, ce7, we1, we7, wd1, wd7, dr1, dr7});
    end
    $display("lat_sweep: lat1=%0d lat7=%0d", lat1, lat7);
  endtask

  task automatic test_random();
    int mode, gap;
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(1, 3);
      run_txn(mode[0], mode[1], $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst = 1'b1; ice = 1'b0; dce = 1'b0; flush = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dwdata = 32'd0; dwe = 4'd0;
    ice1 = 1'b0; ice7 = 1'b0; iaddr1 = 32'd0; iaddr7 = 32'd0;
    #1;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_flush_fetch();
    test_flush_store();
    test_reset_mid();
    test_lat_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning SRAM access cycles per transaction; legal range 1..7.
REQ-002 SHALL have port cpu_clk_50M  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ice  input  1  instruction fetch request, held by requester until inst_valid.
REQ-005 SHALL have port iaddr  input  32  fetch address.
REQ-006 SHALL have port inst  output  32  fetched word, registered, valid only while inst_valid.
REQ-007 SHALL have port inst_valid  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dce  input  1  data request, held until d_valid.
REQ-009 SHALL have port dwe  input  4  byte write enables; 0 = read.
REQ-010 SHALL have ports daddr  input  32  and dwdata  input  32  data address and store data.
REQ-011 SHALL have port drdata  output  32  load result, registered, valid only while d_valid.
REQ-012 SHALL have port d_valid  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port flush  input  1  pipeline flush from exception logic.
REQ-014 SHALL have port stallreq  output  1  combinational pipeline stall request.
REQ-015 SHALL have ports sram_ce  output  1, sram_we  output  4, sram_addr  output  32, sram_wdata  output  32, sram_rdata  input  32  single shared SRAM port.

Function
REQ-016 SHALL implement FSM states IDLE, ACC_I, ACC_D, plus a 3-bit access counter.
REQ-017 In IDLE, SHALL grant dce before ice (data priority); a granted request's address/dwe/dwdata SHALL be latched at the edge ending the IDLE cycle, entering ACC_D or ACC_I.
REQ-018 A requester whose valid pulses this cycle SHALL be excluded from arbitration this cycle (no double service of a held request).
REQ-019 In ACC_x, SHALL drive sram_ce=1, sram_addr=latched address; ACC_D drives sram_we/sram_wdata from latched values, ACC_I drives sram_we=0, sram_wdata=0.
REQ-020 SHALL remain in ACC_x exactly MEM_LAT cycles; on the last, sample sram_rdata into inst/drdata and return to IDLE.
REQ-021 inst_valid/d_valid SHALL pulse high for exactly the one cycle after the last access cycle; latency request-seen-in-IDLE to valid = MEM_LAT+1 cycles.
REQ-022 Outside ACC_x, sram_ce, sram_we, sram_addr, sram_wdata SHALL be 0.
REQ-023 stallreq SHALL be 1 when state!=IDLE, or in IDLE when (ice and not inst_valid) or (dce and not d_valid); else 0.
REQ-024 flush in IDLE SHALL block both grants that cycle.
REQ-025 flush during ACC_I SHALL abort: next cycle IDLE, sram_ce=0, inst_valid not pulsed, inst unchanged.
REQ-026 flush during ACC_D SHALL be ignored; the access completes and d_valid pulses normally.
REQ-027 Simultaneous ice and dce in IDLE SHALL serve data first, then fetch starting in the d_valid cycle (back-to-back, no idle bubble).
REQ-028 Counter SHALL reset to 0 on each state entry and never wrap.

Reset
REQ-029 cpu_rst=1 at an edge SHALL force IDLE, counter 0, inst=0, drdata=0, inst_valid=0, d_valid=0, all sram_* outputs 0, regardless of state (including mid-access, discarding any pending result).
REQ-030 During reset cycles stallreq SHALL follow REQ-023 with state IDLE and valids 0.

Verification (MEM_LAT=2)
REQ-031 ice=1, iaddr=0xBFC00000, sram_rdata=0x24080001 -> sram_ce high cycles 1-2 with addr 0xBFC00000, inst_valid & inst=0x24080001 cycle 3, stallreq high cycles 0-2, low cycle 3.
REQ-032 ice=1 and dce=1 (dwe=0xF, daddr=0x80000010, dwdata=0xDEADBEEF) same cycle -> write cycles 1-2, d_valid cycle 3, fetch cycles 4-5, inst_valid cycle 6.
REQ-033 flush=1 in first ACC_I cycle -> sram_ce=0 next cycle, no inst_valid, state IDLE.
REQ-034 flush=1 during ACC_D store -> sram_we=0xF both cycles, d_valid still pulses.
REQ-035 cpu_rst=1 in second ACC_D cycle -> next cycle all outputs 0, no d_valid, new ice served normally afterward.
REQ-036 MEM_LAT=1 sweep: fetch valid 2 cycles after request; MEM_LAT=7: 8 cycles.
